mem_port_arbiter: RTL and testbench

Shares one downstream memory port between the core's three memory clients: instruction fetch read (port I), data read (port R) and data write (port W). It sits between the IF/MA stages and the memory or cache interface. Default priority is W > R > I, with a starvation guard for I. It also supports aborting an in-flight fetch after a taken jump, so a stale instruction is never delivered.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I), data read (R) and data write (W); priority is W > R > I, with a starvation guard for I.
// A grant registers one cycle after the request and needs one IDLE cycle between transactions; a requester holds its req until its ack pulses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_len,
  input  logic              i_abort,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [1:0]        r_len,
  output logic              r_ack,
  output logic [DATA_W-1:0] r_rdata,

  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [1:0]        w_len,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ack,

  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_len,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_din,
  input  logic              m_ack,

  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        len;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_R    = 2'd2;
  localparam logic [1:0] OWN_W    = 2'd3;
  localparam logic [3:0] CNT_LIM  = 4'(STARVE_LIM);

  state_e     state_q;
  logic [1:0] owner_q;
  logic       abort_q;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       m_re_q, m_we_q;
  cmd_t       cmd_q;

  logic       i_elig;
  logic       starved;
  logic [1:0] grant;
  cmd_t       grant_cmd;
  logic       ack_ok;

  // An abort seen in IDLE removes the fetch from this cycle's arbitration.
  always_comb begin
    i_elig  = i_req & ~i_abort;
    starved = (starve_cnt_q == CNT_LIM);
    grant   = OWN_NONE;
    if (state_q == S_IDLE) begin
      if (i_elig && starved) grant = OWN_I;
      else if (w_req)        grant = OWN_W;
      else if (r_req)        grant = OWN_R;
      else if (i_elig)       grant = OWN_I;
    end
  end

  always_comb begin
    grant_cmd = '0;
    case (grant)
      OWN_I:   grant_cmd = '{addr: i_addr, len: i_len, wdata: '0};
      OWN_R:   grant_cmd = '{addr: r_addr, len: r_len, wdata: '0};
      OWN_W:   grant_cmd = '{addr: w_addr, len: w_len, wdata: w_data};
      default: grant_cmd = '0;
    endcase
  end

  // Counts R/W wins while a fetch is waiting; saturates so I keeps top priority until served.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (grant == OWN_I || !i_req)
        starve_cnt_d = 4'd0;
      else if ((grant == OWN_R || grant == OWN_W) && starve_cnt_q != CNT_LIM)
        starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      abort_q      <= 1'b0;
      starve_cnt_q <= 4'd0;
      m_re_q       <= 1'b0;
      m_we_q       <= 1'b0;
      cmd_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (grant != OWN_NONE) begin
            state_q <= S_BUSY;
            owner_q <= grant;
            m_re_q  <= (grant != OWN_W);
            m_we_q  <= (grant == OWN_W);
            cmd_q   <= grant_cmd;
          end
        end
        S_BUSY: begin
          if (owner_q == OWN_I && i_abort) abort_q <= 1'b1;
          if (m_ack) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            m_re_q  <= 1'b0;
            m_we_q  <= 1'b0;
            abort_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // An abort arriving in the completion cycle itself must also hide the stale fetch.
  assign ack_ok  = (state_q == S_BUSY) & m_ack;
  assign i_ack   = ack_ok & (owner_q == OWN_I) & ~abort_q & ~i_abort;
  assign r_ack   = ack_ok & (owner_q == OWN_R);
  assign w_ack   = ack_ok & (owner_q == OWN_W);
  assign i_rdata = i_ack ? m_din : '0;
  assign r_rdata = r_ack ? m_din : '0;

  assign m_re    = m_re_q;
  assign m_we    = m_we_q;
  assign m_addr  = cmd_q.addr;
  assign m_len   = cmd_q.len;
  assign m_wdata = cmd_q.wdata;
  assign busy    = (state_q == S_BUSY);
  assign owner   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each task drives one scenario cycle by cycle and checks hand-computed values.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_abort, r_req, w_req, m_ack;
  logic [AW-1:0] i_addr, r_addr, w_addr;
  logic [1:0]    i_len, r_len, w_len;
  logic [DW-1:0] w_data, m_din;
  logic          i_ack, r_ack, w_ack, m_re, m_we, busy;
  logic [DW-1:0] i_rdata, r_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_len, owner;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_abort(i_abort), .i_ack(i_ack), .i_rdata(i_rdata),
    .r_req(r_req), .r_addr(r_addr), .r_len(r_len), .r_ack(r_ack), .r_rdata(r_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_len(w_len), .w_data(w_data), .w_ack(w_ack),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_din(m_din), .m_ack(m_ack), .busy(busy), .owner(owner)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_abort = 1'b0; m_ack = 1'b1; m_din = 32'hFFFF_FFFF;
    i_req = 1'b1; r_req = 1'b1; w_req = 1'b1;
    i_addr = 32'h10; r_addr = 32'h20; w_addr = 32'h30; i_len = 2'd1; r_len = 2'd1; w_len = 2'd1;
    w_data = 32'h1234_5678;
    cyc(); cyc(); #1;
    tests_run++; if (m_re !== 1'b0)    begin tests_failed++; $display("FAIL rst_m_re: got %0h want 0", m_re); end
    tests_run++; if (m_we !== 1'b0)    begin tests_failed++; $display("FAIL rst_m_we: got %0h want 0", m_we); end
    tests_run++; if (busy !== 1'b0)    begin tests_failed++; $display("FAIL rst_busy: got %0h want 0", busy); end
    tests_run++; if (owner !== 2'd0)   begin tests_failed++; $display("FAIL rst_owner: got %0h want 0", owner); end
    tests_run++; if ({i_ack, r_ack, w_ack} !== 3'b000) begin tests_failed++; $display("FAIL rst_acks: got %b want 000", {i_ack, r_ack, w_ack}); end
    tests_run++; if (i_rdata !== 32'h0 || r_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h/%h want 0/0", i_rdata, r_rdata); end
    tests_run++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_len !== 2'd0) begin tests_failed++; $display("FAIL rst_mbus: got %h/%h/%h want 0", m_addr, m_wdata, m_len); end
    tests_run++; if (dut.starve_cnt_q !== 4'd0) begin tests_failed++; $display("FAIL rst_starve: got %0d want 0", dut.starve_cnt_q); end
    i_req = 1'b0; r_req = 1'b0; w_req = 1'b0; m_ack = 1'b0; m_din = '0;
    rst = 1'b0;
    cyc(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_idle: got %0h want 0", busy); end
  endtask

  task automatic test_single_fetch();
    cyc(); i_req = 1'b1; i_addr = 32'h100; i_len = 2'd2; #1;
    tests_run++; if (m_re !== 1'b0) begin tests_failed++; $display("FAIL sf_req_cycle_m_re: got %0h want 0", m_re); end
    cyc(); #1;
    tests_run++; if (m_re !== 1'b1 || m_we !== 1'b0) begin tests_failed++; $display("FAIL sf_grant_en: got re=%0h we=%0h want 1/0", m_re, m_we); end
    tests_run++; if (m_addr !== 32'h100 || m_len !== 2'd2) begin tests_failed++; $display("FAIL sf_addr_len: got %h/%0d want 100/2", m_addr, m_len); end
    tests_run++; if (owner !== 2'd1 || busy !== 1'b1) begin tests_failed++; $display("FAIL sf_owner: got %0d busy %0h want 1/1", owner, busy); end
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      tests_run++; if (i_ack !== 1'b0 || m_re !== 1'b1) begin tests_failed++; $display("FAIL sf_wait%0d: got ack=%0h re=%0h want 0/1", k, i_ack, m_re); end
    end
    cyc(); m_ack = 1'b1; m_din = 32'hDEAD_BEEF; #1;
    tests_run++; if (i_ack !== 1'b1) begin tests_failed++; $display("FAIL sf_ack: got %0h want 1", i_ack); end
    tests_run++; if (i_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL sf_rdata: got %h want deadbeef", i_rdata); end
    tests_run++; if (r_ack !== 1'b0 || w_ack !== 1'b0) begin tests_failed++; $display("FAIL sf_other_acks: got %0h/%0h want 0/0", r_ack, w_ack); end
    cyc(); m_ack = 1'b0; i_req = 1'b0; #1;
    tests_run++; if (i_ack !== 1'b0 || m_re !== 1'b0) begin tests_failed++; $display("FAIL sf_done: got ack=%0h re=%0h want 0/0", i_ack, m_re); end
    tests_run++; if (owner !== 2'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL sf_owner_clear: got %0d/%0h want 0/0", owner, busy); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_own [6];
    exp_own = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    cyc();
    w_req = 1'b1; w_addr = 32'h400; w_len = 2'd3; w_data = 32'hA5A5_0001;
    r_req = 1'b1; r_addr = 32'h300; r_len = 2'd2;
    i_req = 1'b1; i_addr = 32'h200; i_len = 2'd2;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c > 0) begin
        case (exp_own[c-1])
          2'd3: w_req = 1'b0;
          2'd2: r_req = 1'b0;
          2'd1: i_req = 1'b0;
          default: ;
        endcase
      end
      m_ack = busy; m_din = 32'h5000 + c;
      #1;
      tests_run++; if (owner !== exp_own[c]) begin tests_failed++; $display("FAIL pri_owner[%0d]: got %0d want %0d", c, owner, exp_own[c]); end
      tests_run++; if ({w_ack, r_ack, i_ack} !== {exp_own[c] == 2'd3, exp_own[c] == 2'd2, exp_own[c] == 2'd1}) begin
        tests_failed++; $display("FAIL pri_acks[%0d]: got w%0h r%0h i%0h for owner %0d", c, w_ack, r_ack, i_ack, exp_own[c]);
      end
      tests_run++; if (m_we !== (exp_own[c] == 2'd3)) begin tests_failed++; $display("FAIL pri_m_we[%0d]: got %0h want %0h", c, m_we, exp_own[c] == 2'd3); end
      if (exp_own[c] == 2'd3) begin
        tests_run++; if (m_wdata !== 32'hA5A5_0001 || m_addr !== 32'h400) begin tests_failed++; $display("FAIL pri_wdata: got %h@%h want a5a50001@400", m_wdata, m_addr); end
      end
      if (exp_own[c] == 2'd2) begin
        tests_run++; if (r_rdata !== 32'h5000 + c) begin tests_failed++; $display("FAIL pri_rdata: got %h want %h", r_rdata, 32'h5000 + c); end
      end
    end
    m_ack = 1'b0;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_own [10];
    logic [3:0] exp_cnt [10];
    exp_own = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    exp_cnt = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd0, 4'd0};
    cyc();
    i_req = 1'b1; i_addr = 32'h600; r_req = 1'b1; r_addr = 32'h700;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c > 0 && exp_own[c-1] == 2'd1) begin i_req = 1'b0; r_req = 1'b0; end
      m_ack = busy; m_din = 32'h7000 + c;
      #1;
      tests_run++; if (owner !== exp_own[c]) begin tests_failed++; $display("FAIL stv_owner[%0d]: got %0d want %0d", c, owner, exp_own[c]); end
      tests_run++; if (dut.starve_cnt_q !== exp_cnt[c]) begin tests_failed++; $display("FAIL stv_cnt[%0d]: got %0d want %0d", c, dut.starve_cnt_q, exp_cnt[c]); end
    end
    m_ack = 1'b0;
  endtask

  task automatic test_abort();
    logic saw_i_ack;
    saw_i_ack = 1'b0;
    cyc(); i_req = 1'b1; i_addr = 32'h200; i_len = 2'd2; #1;
    cyc(); i_abort = 1'b1; r_req = 1'b1; r_addr = 32'h300; r_len = 2'd1; #1;
    tests_run++; if (owner !== 2'd1 || m_re !== 1'b1) begin tests_failed++; $display("FAIL ab_grant: got owner %0d re %0h want 1/1", owner, m_re); end
    saw_i_ack |= i_ack;
    cyc(); i_abort = 1'b0; i_req = 1'b0; #1;
    saw_i_ack |= i_ack;
    tests_run++; if (dut.abort_q !== 1'b1) begin tests_failed++; $display("FAIL ab_flag: got %0h want 1", dut.abort_q); end
    cyc(); m_ack = 1'b1; m_din = 32'hBAD0_BAD0; #1;
    saw_i_ack |= i_ack;
    tests_run++; if (i_ack !== 1'b0 || i_rdata !== 32'h0) begin tests_failed++; $display("FAIL ab_suppressed: got ack %0h data %h want 0/0", i_ack, i_rdata); end
    tests_run++; if (r_ack !== 1'b0) begin tests_failed++; $display("FAIL ab_r_ack: got %0h want 0", r_ack); end
    cyc(); m_ack = 1'b0; #1;
    saw_i_ack |= i_ack;
    tests_run++; if (busy !== 1'b0 || m_re !== 1'b0 || dut.abort_q !== 1'b0) begin tests_failed++; $display("FAIL ab_idle: got busy %0h re %0h flag %0h want 0/0/0", busy, m_re, dut.abort_q); end
    cyc(); m_ack = 1'b1; m_din = 32'h0000_0055; #1;
    saw_i_ack |= i_ack;
    tests_run++; if (owner !== 2'd2 || m_addr !== 32'h300 || m_len !== 2'd1) begin tests_failed++; $display("FAIL ab_r_grant: got owner %0d addr %h len %0d want 2/300/1", owner, m_addr, m_len); end
    tests_run++; if (r_ack !== 1'b1 || r_rdata !== 32'h55) begin tests_failed++; $display("FAIL ab_r_done: got ack %0h data %h want 1/55", r_ack, r_rdata); end
    cyc(); m_ack = 1'b0; r_req = 1'b0; #1;
    saw_i_ack |= i_ack;
    tests_run++; if (saw_i_ack !== 1'b0) begin tests_failed++; $display("FAIL ab_no_i_ack: got %0h want 0", saw_i_ack); end
  endtask

  task automatic test_reset_busy();
    cyc(); w_req = 1'b1; w_addr = 32'h800; w_len = 2'd1; w_data = 32'hCAFE_F00D; #1;
    cyc(); #1;
    tests_run++; if (m_we !== 1'b1 || owner !== 2'd3 || m_wdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rb_grant: got we %0h owner %0d data %h want 1/3/cafef00d", m_we, owner, m_wdata); end
    rst = 1'b1; m_ack = 1'b1; #1;
    tests_run++; if (m_we !== 1'b0 || w_ack !== 1'b0) begin tests_failed++; $display("FAIL rb_async: got we %0h ack %0h want 0/0", m_we, w_ack); end
    tests_run++; if (busy !== 1'b0 || owner !== 2'd0) begin tests_failed++; $display("FAIL rb_state: got busy %0h owner %0d want 0/0", busy, owner); end
    cyc(); m_ack = 1'b0; #1;
    tests_run++; if (m_we !== 1'b0) begin tests_failed++; $display("FAIL rb_held: got %0h want 0", m_we); end
    rst = 1'b0;
    cyc(); #1;
    tests_run++; if (m_we !== 1'b1 || owner !== 2'd3) begin tests_failed++; $display("FAIL rb_regrant: got we %0h owner %0d want 1/3", m_we, owner); end
    m_ack = 1'b1; #1;
    tests_run++; if (w_ack !== 1'b1) begin tests_failed++; $display("FAIL rb_w_ack: got %0h want 1", w_ack); end
    cyc(); m_ack = 1'b0; w_req = 1'b0; #1;
    tests_run++; if (busy !== 1'b0 || m_we !== 1'b0) begin tests_failed++; $display("FAIL rb_done: got busy %0h we %0h want 0/0", busy, m_we); end
  endtask

  task automatic test_spurious_ack();
    cyc(); m_ack = 1'b1; m_din = 32'h1111_2222; #1;
    tests_run++; if ({i_ack, r_ack, w_ack} !== 3'b000) begin tests_failed++; $display("FAIL sp_acks: got %b want 000", {i_ack, r_ack, w_ack}); end
    tests_run++; if (i_rdata !== 32'h0 || r_rdata !== 32'h0) begin tests_failed++; $display("FAIL sp_rdata: got %h/%h want 0/0", i_rdata, r_rdata); end
    cyc(); m_ack = 1'b0; #1;
    tests_run++; if (busy !== 1'b0 || owner !== 2'd0 || m_re !== 1'b0 || m_we !== 1'b0) begin
      tests_failed++; $display("FAIL sp_state: got busy %0h owner %0d re %0h we %0h want 0", busy, owner, m_re, m_we);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_abort();
    test_reset_busy();
    test_spurious_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
